// File: rtl/memory_mapped_io_uart_rx.sv
// rtl/memory_mapped_io_uart_rx.sv - 8N1 UART receiver feeding a 256-byte MMIO ring buffer
// Hardware owns queue_tail; software owns queue_head and consumes bytes between them.
module memory_mapped_io_uart_rx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic        input_cmd_start,
  input  logic        input_cmd_write,
  output logic        output_cmd_ready,
  input  logic [31:0] input_addr,
  output logic [31:0] output_rdata,
  output logic        output_rdata_valid,
  input  logic [31:0] input_wdata
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta, rx_sync, rx_prev;
  logic [7:0]    queue_head, queue_tail;
  logic          overflow, framing_err;
  logic [7:0]    mem [0:255];

  logic full, stop_sample, commit, bus_wr;
  logic [5:0] word_idx;
  logic unused_wdata;

  assign output_cmd_ready   = 1'b1;
  assign output_rdata_valid = 1'b1;
  assign unused_wdata       = ^input_wdata[31:8];

  assign full        = (queue_tail + 8'd1) == queue_head;
  assign stop_sample = (state == STOP) && (cnt == '0);
  assign commit      = stop_sample && rx_sync && !full;
  assign bus_wr      = input_cmd_start && input_cmd_write;
  assign word_idx    = input_addr[7:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      queue_head  <= '0;
      queue_tail  <= '0;
      overflow    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;

      if (bus_wr && input_addr == 32'h104) queue_head <= input_wdata[7:0];
      // Clear first so a same-cycle hardware set below takes priority.
      if (bus_wr && input_addr == 32'h108) begin
        overflow    <= 1'b0;
        framing_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rx_sync) state <= IDLE;
          else begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shift <= {rx_sync, shift[7:1]};
            cnt   <= FULL_LOAD;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state <= IDLE;
            if (!rx_sync) framing_err <= 1'b1;
            else if (full) overflow <= 1'b1;
            else queue_tail <= queue_tail + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[queue_tail] <= shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_rdata <= '0;
    end else if (input_addr[31:8] == 24'd0) begin
      output_rdata <= {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                       mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};
    end else begin
      case (input_addr)
        32'h100: output_rdata <= {24'd0, queue_tail};
        32'h104: output_rdata <= {24'd0, queue_head};
        32'h108: output_rdata <= {30'd0, framing_err, overflow};
        default: output_rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_mapped_io_uart_rx.sv
// tb/tb_memory_mapped_io_uart_rx.sv - self-checking bench for memory_mapped_io_uart_rx
module tb_memory_mapped_io_uart_rx;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        input_cmd_start, input_cmd_write;
  logic        output_cmd_ready, output_rdata_valid;
  logic [31:0] input_addr, output_rdata, input_wdata;

  memory_mapped_io_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .input_cmd_start(input_cmd_start), .input_cmd_write(input_cmd_write),
    .output_cmd_ready(output_cmd_ready), .input_addr(input_addr),
    .output_rdata(output_rdata), .output_rdata_valid(output_rdata_valid),
    .input_wdata(input_wdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] idx; logic [7:0] data; } sb_t;
  typedef struct { logic [7:0] data; logic stop; } frame_t;
  typedef struct { logic [31:0] addr; logic [31:0] exp; string name; } rd_t;

  sb_t    sb_q[$];
  frame_t frames[4];
  rd_t    rd_tab[6];
  int     n_checks = 0;
  int     n_fail = 0;

  logic [7:0] m_head, m_tail;
  logic [1:0] m_stat;
  logic [31:0] rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk) input_addr = a;
    @(posedge clk);
    @(negedge clk) d = output_rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    input_addr = a; input_wdata = d; input_cmd_start = 1'b1; input_cmd_write = 1'b1;
    @(negedge clk);
    input_cmd_start = 1'b0; input_cmd_write = 1'b0;
    if (a == 32'h104) m_head = d[7:0];
    if (a == 32'h108) m_stat = 2'b00;
  endtask

  task automatic line_bit(input logic v);
    @(negedge clk) uart_rx = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(data[i]);
    line_bit(stop);
    @(negedge clk) uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    if (!stop) m_stat[1] = 1'b1;
    else if (m_tail + 8'd1 == m_head) m_stat[0] = 1'b1;
    else begin
      sb_q.push_back('{idx: m_tail, data: data});
      m_tail = m_tail + 8'd1;
    end
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] w;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read({24'd0, e.idx[7:2], 2'b00}, w);
      check($sformatf("byte[%0d]", e.idx), {24'd0, w[e.idx[1:0]*8 +: 8]}, {24'd0, e.data});
    end
  endtask

  task automatic run_reads(input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      bus_read(rd_tab[i].addr, d);
      check(rd_tab[i].name, d, rd_tab[i].exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_head = 0; m_tail = 0; m_stat = 0;
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic reg_table();
    rd_tab[0] = '{32'h100, {24'd0, m_tail}, "tail"};
    rd_tab[1] = '{32'h104, {24'd0, m_head}, "head"};
    rd_tab[2] = '{32'h108, {30'd0, m_stat}, "status"};
    rd_tab[3] = '{32'h10C, 32'd0, "unmapped_10c"};
    rd_tab[4] = '{32'h200, 32'd0, "unmapped_200"};
    rd_tab[5] = '{32'hFFFF_FF00, 32'd0, "unmapped_high"};
    run_reads(6);
  endtask

  initial begin
    rst = 1'b1; uart_rx = 1'b1; input_addr = 32'h100; input_wdata = 0;
    input_cmd_start = 0; input_cmd_write = 0;
    m_head = 0; m_tail = 0; m_stat = 0;
    repeat (2) @(negedge clk);
    check("rdata_in_reset", output_rdata, 32'd0);
    check("cmd_ready", {31'd0, output_cmd_ready}, 32'd1);
    check("rdata_valid", {31'd0, output_rdata_valid}, 32'd1);
    do_reset();
    reg_table();

    // single byte
    send_frame(8'h41, 1'b1);
    reg_table();
    drain();

    // four bytes then consume
    do_reset();
    frames[0] = '{8'h11, 1'b1}; frames[1] = '{8'h22, 1'b1};
    frames[2] = '{8'h33, 1'b1}; frames[3] = '{8'h44, 1'b1};
    for (int i = 0; i < 4; i++) send_frame(frames[i].data, frames[i].stop);
    bus_read(32'h000, rv);
    check("word0_four", rv, 32'h4433_2211);
    drain();
    bus_write(32'h104, 32'h0000_0004);
    reg_table();

    // wrap and full
    do_reset();
    bus_write(32'h104, 32'd0);
    for (int i = 0; i < 256; i++) send_frame(8'(i * 7 + 3), 1'b1);
    reg_table();
    check("tail_full", {24'd0, m_tail}, 32'd255);
    drain();
    bus_write(32'h108, 32'hFFFF_FFFF);
    reg_table();
    bus_write(32'h104, 32'd10);
    send_frame(8'hC3, 1'b1);
    bus_read(32'h0FC, rv);
    check("wrap_lane3", {24'd0, rv[31:24]}, 32'h0000_00C3);
    reg_table();
    drain();

    // framing error then recovery
    do_reset();
    frames[0] = '{8'h55, 1'b0}; frames[1] = '{8'h66, 1'b1};
    for (int i = 0; i < 2; i++) begin
      send_frame(frames[i].data, frames[i].stop);
      reg_table();
    end
    drain();
    bus_write(32'h108, 32'd0);

    // glitch: two low cycles, then a normal frame must still land
    @(negedge clk) uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    reg_table();
    send_frame(8'h77, 1'b1);
    reg_table();
    drain();

    // reset during bit 3 of 0xA5
    line_bit(1'b0);
    for (int i = 0; i < 3; i++) line_bit(1'(8'hA5 >> i));
    @(negedge clk) uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    input_addr = 32'h100;
    rst = 1'b1;
    @(negedge clk) uart_rx = 1'b1;
    check("rdata_mid_reset", output_rdata, 32'd0);
    repeat (2 * CPB) @(negedge clk);
    rst = 1'b0;
    m_head = 0; m_tail = 0; m_stat = 0;
    sb_q.delete();
    repeat (2 * CPB) @(negedge clk);
    reg_table();
    send_frame(8'h5A, 1'b1);
    reg_table();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_mapped_io_uart_rx.md
# memory_mapped_io_uart_rx

Memory-mapped UART receiver: deserialises 8N1 frames from `uart_rx` and pushes each received byte into a 256-byte ring buffer. The CPU polls `queue_tail` (hardware-owned) and advances `queue_head` (software-owned) to consume bytes. It sits on the same MMIO command bus as the UART transmitter and is its receive-side counterpart, with a mirrored head/tail ownership.

## Interface
- `CLKS_PER_BIT`, 234, clock cycles per UART bit (27 MHz / 115200); must be ≥ 4.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  serial input; asynchronous; idles high.
- `input_cmd_start`  in  1  bus command strobe.
- `input_cmd_write`  in  1  1 = write, 0 = read.
- `output_cmd_ready`  out  1  tied 1.
- `input_addr`  in  32  byte address.
- `output_rdata`  out  32  registered read data.
- `output_rdata_valid`  out  1  tied 1.
- `input_wdata`  in  32  write data.

## Operation
- **Address map:**
  - 0x000–0x0FC: buffer words, read-only; byte n of the stream is at word n[7:2], lane n[1:0] (lane 0 = bits 7:0).
  - 0x100: `queue_tail`, read-only.
  - 0x104: `queue_head`, read/write; bits 7:0 are used.
  - 0x108: status, bit0 = overflow, bit1 = framing error, both sticky; any write clears both.
  - Reads of other addresses return 0; writes to them are ignored.
- **Bus reads:** `output_rdata` is updated every cycle from `input_addr`, regardless of `input_cmd_start`. Pointers are zero-extended to 32 bits.
- **Bus writes:** take effect only when `input_cmd_start && input_cmd_write`.
- **Input synchroniser:** `uart_rx` passes through a 2-flop synchroniser, reset to 1. A falling edge is detected on the synchronised signal.
- **Receive FSM:**
  - IDLE: on a falling edge, load the bit counter with CLKS_PER_BIT/2 − 1 and go to START.
  - START: when the counter reaches 0, sample. If high, this is a glitch: go to IDLE. If low, load CLKS_PER_BIT − 1 and go to DATA with bit index 0.
  - DATA: each time the counter reaches 0, shift the sample in LSB-first and reload. After bit 7, go to STOP.
  - STOP: when the counter reaches 0, sample. If 1, commit the byte. If 0, set the framing-error flag and discard the byte. Go to IDLE in both cases.
- **Commit:**
  - Full means `queue_tail + 1 == queue_head` (8-bit wrap), giving 255 usable entries.
  - If full: drop the byte, set the overflow flag, leave `queue_tail` unchanged.
  - Otherwise: write the byte into lane `queue_tail[1:0]` of word `queue_tail[7:2]` (other lanes unchanged), then `queue_tail <= queue_tail + 1`, wrapping 255→0.
- **Empty** is `head == tail`. Hardware never checks head validity; software must not move head past tail.

## Timing
- **Reset values:** `output_rdata` = 0, `queue_head` = 0, `queue_tail` = 0, status = 0, FSM = IDLE, synchroniser = 1. Buffer RAM is not reset.
- **Read latency:** 1 cycle. Address presented at edge k gives data valid after edge k+1.
- **Commit timing:** the byte write and tail increment happen on the edge of the stop-bit sample. The new tail is visible to a read issued on the next cycle. A read of 0x100 in the same cycle as a commit returns the old tail.
- **Head write vs. commit in the same cycle:** the full check uses the pre-write (registered) head.
- **Status clear vs. set in the same cycle:** set wins.
- **Sampling point:** the first edge is detected 2–3 cycles after the line falls (synchroniser delay). Samples then land at mid-bit ±1 cycle.
- **Mid-frame reset:** the FSM returns to IDLE and the partial byte is lost. Receiving resumes at the next falling edge after reset is released.

## Test plan
- **Single byte:** CLKS_PER_BIT=8, send 0x41 → tail reads 1, word 0x000 bits 7:0 = 0x41, status = 0.
- **Four bytes then consume:** send 0x11, 0x22, 0x33, 0x44 → word 0 = 0x44332211, tail = 4. Write head = 4 → head reads 4.
- **Wrap and full:**
  - Preload head = 0. Send 256 bytes → tail = 255 after 255 bytes; byte 256 is dropped, status bit0 = 1.
  - Write 0x108 → status = 0.
  - Write head = 10, send one byte → it lands at lane 3 of word 0x0FC and tail wraps to 0.
- **Framing error:** send 0x55 with the stop bit low → status bit1 = 1, tail unchanged. A following valid 0x66 is received normally.
- **Glitch:** hold `uart_rx` low for 2 cycles → no commit, FSM back in IDLE, status = 0.
- **Reset mid-frame:** assert `rst` during bit 3 of 0xA5 → pointers and `output_rdata` are 0. The next full 0x5A frame is received as byte 0.
